// File: rtl/io_port_ctrl.sv
// Bridges an external byte device to a simple computer's INPR/OUTR registers via FGI/FGO flags.
// Input is a three-state handshake; output bytes queue in a small FIFO toward the external sink.
module io_port_ctrl #(
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] INPR_in,
    output logic       set_FGI,
    input  logic       FGI_out,
    input  logic [7:0] OUTR_out,
    output logic       set_FGO,
    input  logic       FGO_out,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready
);

    localparam int unsigned PtrW = $clog2(OUT_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t FullCount = cnt_t'(OUT_DEPTH);

    typedef enum logic [1:0] {InIdle, InSet, InWait} in_state_e;
    typedef enum logic {OutRearm, OutArmed} out_state_e;

    in_state_e  in_state_q;
    logic       in_ready_q;
    logic       set_fgi_q;
    logic [7:0] inpr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q <= InIdle;
            in_ready_q <= 1'b1;
            set_fgi_q  <= 1'b0;
            inpr_q     <= 8'h00;
        end else begin
            case (in_state_q)
                InIdle: begin
                    if (in_valid) begin
                        in_state_q <= InSet;
                        in_ready_q <= 1'b0;
                        set_fgi_q  <= 1'b1;
                        inpr_q     <= in_data;
                    end
                end
                InSet: begin
                    in_state_q <= InWait;
                    set_fgi_q  <= 1'b0;
                end
                InWait: begin
                    // FGI cleared means the CPU has consumed INPR
                    if (!FGI_out) begin
                        in_state_q <= InIdle;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    in_state_q <= InIdle;
                    in_ready_q <= 1'b1;
                    set_fgi_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign set_FGI  = set_fgi_q;
    assign INPR_in  = inpr_q;

    out_state_e      out_state_q;
    cnt_t            count_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [7:0]      mem_q [OUT_DEPTH];
    logic            full;
    logic            push;
    logic            pop;

    assign full = (count_q == FullCount);
    // Arming only happens with room left, so a push can never land on a full FIFO
    assign push = (out_state_q == OutArmed) && !FGO_out;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state_q <= OutRearm;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            case (out_state_q)
                OutRearm: if (!full) out_state_q <= OutArmed;
                OutArmed: if (!FGO_out) out_state_q <= OutRearm;
            endcase
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= OUTR_out;
    end

    // Gated by rst so the pulse is suppressed during reset yet appears as soon as it lifts
    assign set_FGO   = !rst && (out_state_q == OutRearm) && !full;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;

endmodule
